// File: rtl/axi_rd_ctrl_pkg.sv
// Shared types and constants for the AXI read controller.
package axi_rd_ctrl_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0]  RESP_DECERR = 2'b11;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;

  // Latched read request as presented on the AR channel.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_req_t;

  // Anything other than a plain OKAY taints the burst.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_rd_ctrl.sv
// Single-outstanding AXI read controller between load_buffer and DRAM.
// Issues one INCR burst per accepted request and forwards R beats with zero
// latency. Optional macro AXI_RD_RETRY_EN re-issues a burst that saw an error
// response, up to MAX_RETRY times.
module axi_rd_ctrl
  import axi_rd_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_axi_arvld,
  input  logic [ID_W-1:0]      load_axi_arid,
  input  logic [ADDR_W-1:0]    load_axi_arraddr,
  input  logic [LEN_W-1:0]     load_axi_arlen,
  input  logic [SIZE_W-1:0]    load_axi_arsize,
  input  logic                 load_axi_rrdy,
  output logic                 ctrl_dram_arrdy,
  output logic [ID_W-1:0]      ctrl_sram_rid,
  output logic [DATA_W-1:0]    ctrl_sram_rdata,
  output logic [RESP_W-1:0]    ctrl_sram_rresp,
  output logic                 ctrl_sram_rlast,
  output logic                 ctrl_sram_rvld,
  output logic [ID_W-1:0]      m_arid,
  output logic [ADDR_W-1:0]    m_araddr,
  output logic [LEN_W-1:0]     m_arlen,
  output logic [SIZE_W-1:0]    m_arsize,
  output logic [BURST_W-1:0]   m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [ID_W-1:0]      m_rid,
  input  logic [DATA_W-1:0]    m_rdata,
  input  logic [RESP_W-1:0]    m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic                 rd_done,
  output logic                 rd_err
);

`ifdef AXI_RD_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  ar_req_t              req_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 burst_err_q;
  logic                 rd_done_q;
  logic                 rd_err_q;

  logic accept, do_retry, done_d;
  logic r_acc, id_ok, fwd, at_last, burst_end, last_err, beat_err, err_any, retry_ok;

  // R-beat decode: acceptance, id match and last-beat bookkeeping.
  assign r_acc     = (state_q == ST_DATA) & m_rvalid & load_axi_rrdy;
  assign id_ok     = (m_rid == req_q.id);
  assign fwd       = r_acc & id_ok;
  assign at_last   = (cnt_q == CNT_W'(req_q.len));
  assign burst_end = fwd & (m_rlast | at_last);
  assign last_err  = fwd & (m_rlast ^ at_last);
  assign beat_err  = fwd & resp_is_err(m_rresp);
  assign err_any   = burst_err_q | beat_err;
  assign retry_ok  = RETRY_EN & (retry_q < MAX_RETRY_C);

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    do_retry = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_axi_arvld) begin
          accept  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (burst_end) begin
          if (err_any && retry_ok) begin
            do_retry = 1'b1;
            state_d  = ST_ADDR;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request fields held for the whole burst, including retries.
  always_ff @(posedge clk) begin
    if (!rst_n)      req_q <= '0;
    else if (accept) req_q <= '{id: load_axi_arid, addr: load_axi_arraddr,
                                len: load_axi_arlen, size: load_axi_arsize};
  end

  // Beat counter, restarted for every (re-)issued burst.
  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (accept || do_retry) cnt_q <= '0;
    else if (fwd)                cnt_q <= cnt_q + CNT_W'(1);
  end

  // Retry count and per-burst error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_q     <= '0;
      burst_err_q <= 1'b0;
    end else if (accept) begin
      retry_q     <= '0;
      burst_err_q <= 1'b0;
    end else if (do_retry) begin
      retry_q     <= retry_q + RETRY_W'(1);
      burst_err_q <= 1'b0;
    end else if (beat_err) begin
      burst_err_q <= 1'b1;
    end
  end

  // Completion pulse and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_done_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_done_q <= done_d;
      if (accept)
        rd_err_q <= 1'b0;
      else if ((r_acc && !id_ok) || last_err || (done_d && err_any))
        rd_err_q <= 1'b1;
    end
  end

  assign ctrl_dram_arrdy = (state_q == ST_IDLE);
  assign m_arvalid       = (state_q == ST_ADDR);
  assign m_arid          = m_arvalid ? req_q.id   : '0;
  assign m_araddr        = m_arvalid ? req_q.addr : '0;
  assign m_arlen         = m_arvalid ? req_q.len  : '0;
  assign m_arsize        = m_arvalid ? req_q.size : '0;
  assign m_arburst       = m_arvalid ? BURST_INCR : '0;
  assign m_rready        = (state_q == ST_DATA) & load_axi_rrdy;
  assign ctrl_sram_rvld  = fwd;
  assign ctrl_sram_rid   = fwd ? m_rid   : '0;
  assign ctrl_sram_rdata = fwd ? m_rdata : '0;
  assign ctrl_sram_rresp = fwd ? m_rresp : RESP_OKAY;
  assign ctrl_sram_rlast = fwd & m_rlast;
  assign rd_done         = rd_done_q;
  assign rd_err          = rd_err_q;

endmodule

// File: tb/tb_axi_rd_ctrl.sv
// Self-checking bench for axi_rd_ctrl with a transaction-level reference model.
module tb_axi_rd_ctrl;

`ifdef AXI_RD_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_axi_arvld = 1'b0;
  logic [7:0]  load_axi_arid = '0;
  logic [11:0] load_axi_arraddr = '0;
  logic [7:0]  load_axi_arlen = '0;
  logic [2:0]  load_axi_arsize = '0;
  logic        load_axi_rrdy = 1'b1;
  logic        ctrl_dram_arrdy;
  logic [7:0]  ctrl_sram_rid;
  logic [31:0] ctrl_sram_rdata;
  logic [1:0]  ctrl_sram_rresp;
  logic        ctrl_sram_rlast, ctrl_sram_rvld;
  logic [7:0]  m_arid;
  logic [11:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [7:0]  m_rid = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0, m_rvalid = 1'b0;
  logic        m_rready, rd_done, rd_err;

  always #5 clk = ~clk;

  axi_rd_ctrl #(.MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_axi_arvld(load_axi_arvld), .load_axi_arid(load_axi_arid),
    .load_axi_arraddr(load_axi_arraddr), .load_axi_arlen(load_axi_arlen),
    .load_axi_arsize(load_axi_arsize), .load_axi_rrdy(load_axi_rrdy),
    .ctrl_dram_arrdy(ctrl_dram_arrdy), .ctrl_sram_rid(ctrl_sram_rid),
    .ctrl_sram_rdata(ctrl_sram_rdata), .ctrl_sram_rresp(ctrl_sram_rresp),
    .ctrl_sram_rlast(ctrl_sram_rlast), .ctrl_sram_rvld(ctrl_sram_rvld),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .rd_done(rd_done), .rd_err(rd_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: burst phase (0 idle, 1 address, 2 data) plus expectations.
  bit          chk_en = 1'b0;
  int          mph = 0;
  logic [7:0]  mid = '0;
  logic [11:0] maddr = '0;
  logic [2:0]  msize = '0;
  int          mlen = 0, mcnt = 0, mretry = 0;
  bit          mberr = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
  int          fwd_cnt = 0, last_cnt = 0, done_cnt = 0, arhs_cnt = 0, arv_cnt = 0;
  logic [31:0] last_data = '0;

  // Per-cycle compare against the model, then advance the model across the edge.
  always @(negedge clk) begin
    bit acc, fwd, fin;
    if (chk_en) begin
      chk("arrdy", 32'(ctrl_dram_arrdy), 32'(mph == 0));
      chk("arvalid", 32'(m_arvalid), 32'(mph == 1));
      if (mph == 1) begin
        chk("arid", 32'(m_arid), 32'(mid));
        chk("araddr", 32'(m_araddr), 32'(maddr));
        chk("arlen", 32'(m_arlen), 32'(mlen));
        chk("arsize", 32'(m_arsize), 32'(msize));
        chk("arburst", 32'(m_arburst), 32'd1);
      end
      chk("rready", 32'(m_rready), 32'((mph == 2) && load_axi_rrdy));
      acc = (mph == 2) && m_rvalid && load_axi_rrdy;
      fwd = acc && (m_rid == mid);
      chk("rvld", 32'(ctrl_sram_rvld), 32'(fwd));
      if (fwd) begin
        chk("rid", 32'(ctrl_sram_rid), 32'(m_rid));
        chk("rdata", ctrl_sram_rdata, m_rdata);
        chk("rresp", 32'(ctrl_sram_rresp), 32'(m_rresp));
        chk("rlast", 32'(ctrl_sram_rlast), 32'(m_rlast));
        fwd_cnt++;
        last_data = ctrl_sram_rdata;
        if (ctrl_sram_rlast) last_cnt++;
      end
      chk("rd_done", 32'(rd_done), 32'(exp_done));
      chk("rd_err", 32'(rd_err), 32'(exp_err));
      if (rd_done) done_cnt++;
      if (m_arvalid) arv_cnt++;
      if (m_arvalid && m_arready) arhs_cnt++;
      exp_done = 1'b0;
      if (!rst_n) begin
        mph = 0;
        exp_err = 1'b0;
      end else begin
        case (mph)
          0: if (load_axi_arvld) begin
               mid = load_axi_arid; maddr = load_axi_arraddr;
               mlen = int'(load_axi_arlen); msize = load_axi_arsize;
               mcnt = 0; mretry = 0; mberr = 1'b0; exp_err = 1'b0; mph = 1;
             end
          1: if (m_arready) mph = 2;
          default: begin
            if (acc && !fwd) exp_err = 1'b1;
            if (fwd) begin
              if (m_rresp != 2'b00) mberr = 1'b1;
              fin = (mcnt == mlen);
              if (m_rlast != fin) exp_err = 1'b1;
              if (m_rlast || fin) begin
                if (mberr && RETRY && mretry < MAXR) begin
                  mretry++; mcnt = 0; mberr = 1'b0; mph = 1;
                end else begin
                  if (mberr) exp_err = 1'b1;
                  exp_done = 1'b1; mph = 0;
                end
              end else mcnt++;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [7:0] id, input logic [11:0] addr,
                     input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    load_axi_arvld = 1'b1; load_axi_arid = id; load_axi_arraddr = addr;
    load_axi_arlen = len; load_axi_arsize = size;
    while (!ctrl_dram_arrdy && n < 20) begin tick(); n++; end
    chk("req_wait", 32'(ctrl_dram_arrdy), 32'd1);
    tick();
    load_axi_arvld = 1'b0;
  endtask

  task automatic ar(input int hold, input logic [11:0] exp_addr);
    int n = 0;
    while (!m_arvalid && n < 20) begin tick(); n++; end
    chk("ar_wait", 32'(m_arvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("ar_hold_vld", 32'(m_arvalid), 32'd1);
      chk("ar_hold_addr", 32'(m_araddr), 32'(exp_addr));
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  // Present one R beat until it is accepted; optionally toggle rrdy every cycle.
  bit tog = 1'b0;
  task automatic beat(input logic [7:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    bit took;
    int n = 0;
    m_rvalid = 1'b1; m_rid = id; m_rdata = data; m_rresp = resp; m_rlast = last;
    forever begin
      @(negedge clk);
      took = m_rready;
      @(posedge clk); #1;
      if (tog) load_axi_rrdy = ~load_axi_rrdy;
      if (took) break;
      n++;
      if (n > 30) begin chk("beat_wait", 32'(took), 32'd1); break; end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic burst4(input logic [31:0] base, input int err_beat);
    for (int b = 0; b < 4; b++)
      beat(8'h05, base + 32'(b), (b == err_beat) ? 2'b10 : 2'b00, b == 3);
  endtask

  int f0, d0, h0, v0, l0;
  task automatic snap();
    f0 = fwd_cnt; d0 = done_cnt; h0 = arhs_cnt; v0 = arv_cnt; l0 = last_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick(); tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("reset_arrdy", 32'(ctrl_dram_arrdy), 32'd1);
    chk("reset_arvalid", 32'(m_arvalid), 32'd0);
    chk("reset_rvld", 32'(ctrl_sram_rvld), 32'd0);
    chk("reset_done", 32'(rd_done), 32'd0);
    chk("reset_err", 32'(rd_err), 32'd0);
    tick();

    // Basic 4-beat burst.
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(0, 12'h100); burst4(32'hA000_0000, -1);
    tick(); tick();
    chk("s1_beats", 32'(fwd_cnt - f0), 32'd4);
    chk("s1_rlast", 32'(last_cnt - l0), 32'd1);
    chk("s1_data", last_data, 32'hA000_0003);
    chk("s1_done", 32'(done_cnt - d0), 32'd1);
    chk("s1_err", 32'(rd_err), 32'd0);

    // AR held off for 5 cycles.
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(5, 12'h100); burst4(32'hB000_0000, -1);
    tick(); tick();
    chk("s2_arvalid_cycles", 32'(arv_cnt - v0), 32'd6);
    chk("s2_done", 32'(done_cnt - d0), 32'd1);

    // rrdy toggling; a stray request meanwhile must be ignored.
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(0, 12'h100);
    load_axi_arvld = 1'b1; load_axi_arid = 8'h33; load_axi_arraddr = 12'h777;
    tog = 1'b1;
    for (int b = 0; b < 3; b++) beat(8'h05, 32'hC000_0000 + 32'(b), 2'b00, 1'b0);
    load_axi_arvld = 1'b0;
    beat(8'h05, 32'hC000_0003, 2'b00, 1'b1);
    tog = 1'b0; load_axi_rrdy = 1'b1;
    tick(); tick();
    chk("s3_beats", 32'(fwd_cnt - f0), 32'd4);
    chk("s3_data", last_data, 32'hC000_0003);
    chk("s3_done", 32'(done_cnt - d0), 32'd1);
    chk("s3_ar", 32'(arhs_cnt - h0), 32'd1);

    // SLVERR on beat 2.
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(0, 12'h100); burst4(32'hD000_0000, 1);
`ifdef AXI_RD_RETRY_EN
    ar(0, 12'h100); burst4(32'hD100_0000, -1);
    tick(); tick();
    chk("s4_ar", 32'(arhs_cnt - h0), 32'd2);
    chk("s4_done", 32'(done_cnt - d0), 32'd1);
    chk("s4_err", 32'(rd_err), 32'd0);
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2);
    for (int k = 0; k < 4; k++) begin ar(0, 12'h100); burst4(32'hD200_0000, 1); end
    tick(); tick();
    chk("s4x_ar", 32'(arhs_cnt - h0), 32'd4);
    chk("s4x_done", 32'(done_cnt - d0), 32'd1);
    chk("s4x_err", 32'(rd_err), 32'd1);
`else
    tick(); tick();
    chk("s4_ar", 32'(arhs_cnt - h0), 32'd1);
    chk("s4_done", 32'(done_cnt - d0), 32'd1);
    chk("s4_err", 32'(rd_err), 32'd1);
`endif

    // Early rlast on beat 2 of len=3.
    snap();
    req(8'h05, 12'h140, 8'd3, 3'd2); ar(0, 12'h140);
    beat(8'h05, 32'hE000_0000, 2'b00, 1'b0);
    beat(8'h05, 32'hE000_0001, 2'b00, 1'b1);
    tick(); tick();
    chk("s5_beats", 32'(fwd_cnt - f0), 32'd2);
    chk("s5_done", 32'(done_cnt - d0), 32'd1);
    chk("s5_err", 32'(rd_err), 32'd1);

    // Mismatched id beat is dropped; error cleared by the new request first.
    snap();
    req(8'h05, 12'h180, 8'd1, 3'd2);
    chk("s6_err_cleared", 32'(rd_err), 32'd0);
    ar(0, 12'h180);
    beat(8'h07, 32'hF000_0007, 2'b00, 1'b1);
    beat(8'h05, 32'hF000_0000, 2'b00, 1'b0);
    beat(8'h05, 32'hF000_0001, 2'b00, 1'b1);
    tick(); tick();
    chk("s6_beats", 32'(fwd_cnt - f0), 32'd2);
    chk("s6_data", last_data, 32'hF000_0001);
    chk("s6_done", 32'(done_cnt - d0), 32'd1);
    chk("s6_err", 32'(rd_err), 32'd1);

    // Missing rlast at the final beat.
    snap();
    req(8'h05, 12'h200, 8'd1, 3'd2); ar(0, 12'h200);
    beat(8'h05, 32'h1111_0000, 2'b00, 1'b0);
    beat(8'h05, 32'h1111_0001, 2'b00, 1'b0);
    tick(); tick();
    chk("s7_beats", 32'(fwd_cnt - f0), 32'd2);
    chk("s7_done", 32'(done_cnt - d0), 32'd1);
    chk("s7_err", 32'(rd_err), 32'd1);

    // len=0 single-beat burst.
    snap();
    req(8'h05, 12'h300, 8'd0, 3'd2); ar(0, 12'h300);
    beat(8'h05, 32'h2222_0000, 2'b00, 1'b1);
    tick(); tick();
    chk("s8_beats", 32'(fwd_cnt - f0), 32'd1);
    chk("s8_done", 32'(done_cnt - d0), 32'd1);
    chk("s8_err", 32'(rd_err), 32'd0);

    // Reset in the middle of DATA.
    snap();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(0, 12'h100);
    beat(8'h05, 32'h3333_0000, 2'b00, 1'b0);
    beat(8'h09, 32'h3333_0009, 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s9_arrdy", 32'(ctrl_dram_arrdy), 32'd1);
    chk("s9_arvalid", 32'(m_arvalid), 32'd0);
    chk("s9_rready", 32'(m_rready), 32'd0);
    chk("s9_rvld", 32'(ctrl_sram_rvld), 32'd0);
    chk("s9_done", 32'(rd_done), 32'd0);
    chk("s9_err", 32'(rd_err), 32'd0);
    tick();
    req(8'h05, 12'h100, 8'd3, 3'd2); ar(0, 12'h100); burst4(32'h4444_0000, -1);
    tick(); tick();
    chk("s9_beats", 32'(fwd_cnt - f0), 32'd5);
    chk("s9_done_after", 32'(done_cnt - d0), 32'd1);
    chk("s9_err_after", 32'(rd_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
